// File: rtl/cic_comp_pkg.sv
// Shared constants for the CIC droop compensator: tap count, coefficient
// width, the coefficient set and the MAC engine state encoding.
package cic_comp_pkg;

  localparam int TAPS  = 31;
  localparam int COEFW = 18;
  localparam int TAPW  = $clog2(TAPS);

  // Symmetric compensator, Q1.17. Sum = 141216, so DC gain is about 1.077.
  localparam logic signed [COEFW-1:0] COEFS [TAPS] = '{
    -18'sd32,   18'sd48,  -18'sd64,   18'sd96,  -18'sd128,  18'sd192,
    -18'sd288,  18'sd416, -18'sd608,  18'sd896, -18'sd1312, 18'sd1920,
    -18'sd2816, 18'sd4096, 18'sd8192, 18'sd120000, 18'sd8192, 18'sd4096,
    -18'sd2816, 18'sd1920, -18'sd1312, 18'sd896, -18'sd608,  18'sd416,
    -18'sd288,  18'sd192, -18'sd128,  18'sd96,  -18'sd64,   18'sd48,
    -18'sd32
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_MAC   = 2'd1,
    ST_ROUND = 2'd2,
    ST_OUT   = 2'd3
  } state_t;

endpackage

// File: rtl/cic_comp_sample_ram.sv
// Circular sample store: one write port, one registered read port.
// Contents clear on reset so the filter starts from zero history.
module cic_comp_sample_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    clock_areset_n,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic [AW-1:0]           rd_addr,
  output logic signed [WIDTH-1:0] rd_data
);

  logic signed [WIDTH-1:0] mem [DEPTH];

  // write on valid, read one cycle behind the address
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_data <= '0;
    end else begin
      if (wr_en) mem[wr_addr] <= wr_data;
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/cic_comp_fir.sv
// Decimating droop-compensation FIR behind a CIC decimator. Every sample
// is stored; every DECIM-th sample starts a serial MAC over TAPS taps,
// followed by round/saturate and a one-cycle output strobe.
//
// state    | meaning
// IDLE     | waiting; an accepted trigger arms start for one cycle
// MAC      | TAPS cycles, acc += COEFS[k] * buf[base-k]
// ROUND    | add half LSB, arithmetic shift down to output scale
// OUT      | saturate into data_out, pulse data_out_valid
module cic_comp_fir
  import cic_comp_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DECIM  = 2,
  parameter int WIDTHR = 16
) (
  input  logic                     clock,
  input  logic                     clock_areset_n,
  input  logic                     data_in_valid,
  input  logic signed [WIDTH-1:0]  data_in,
  output logic                     data_out_valid,
  output logic signed [WIDTHR-1:0] data_out,
  output logic                     busy,
  output logic                     overrun,
  input  logic                     overrun_clear
);

  localparam int DEPTH = 2 ** $clog2(TAPS + DECIM);
  localparam int AW    = $clog2(DEPTH);
  localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PRODW = WIDTH + COEFW;
  localparam int ACCW  = WIDTH + COEFW + $clog2(TAPS);
  localparam int SHIFT = COEFW - 1;

  localparam logic signed [ACCW-1:0] RND_HALF = 1 << (COEFW - 2);
  localparam logic signed [ACCW-1:0] OUT_MAX  = {{(ACCW-WIDTHR+1){1'b0}}, {(WIDTHR-1){1'b1}}};
  localparam logic signed [ACCW-1:0] OUT_MIN  = {{(ACCW-WIDTHR+1){1'b1}}, {(WIDTHR-1){1'b0}}};

  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [PHW-1:0]          phase;
  logic                    trig;
  logic                    start;
  state_t                  state;
  logic [TAPW-1:0]         k;
  logic signed [ACCW-1:0]  acc;
  logic signed [WIDTH-1:0] rd_data;
  logic signed [PRODW-1:0] prod;

  assign trig = data_in_valid && (phase == PHW'(DECIM - 1));
  assign prod = PRODW'(COEFS[k]) * PRODW'(rd_data);

  cic_comp_sample_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clock          (clock),
    .clock_areset_n (clock_areset_n),
    .wr_en          (data_in_valid),
    .wr_addr        (wr_ptr),
    .wr_data        (data_in),
    .rd_addr        (rd_ptr),
    .rd_data        (rd_data)
  );

  // store every valid sample and track the decimation phase
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      wr_ptr <= '0;
      phase  <= '0;
    end else if (data_in_valid) begin
      wr_ptr <= wr_ptr + AW'(1);
      phase  <= trig ? '0 : phase + PHW'(1);
    end
  end

  // MAC engine: accept/drop triggers, accumulate, round, saturate, strobe
  always_ff @(posedge clock or negedge clock_areset_n) begin
    if (!clock_areset_n) begin
      state          <= ST_IDLE;
      start          <= 1'b0;
      busy           <= 1'b0;
      overrun        <= 1'b0;
      rd_ptr         <= '0;
      k              <= '0;
      acc            <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      data_out_valid <= 1'b0;
      // read address walks backwards from base; the read port lags by one,
      // which the start cycle absorbs so MAC sees buf[base-k] at step k
      rd_ptr <= rd_ptr - AW'(1);

      if (trig && busy) overrun <= 1'b1;
      else if (overrun_clear) overrun <= 1'b0;

      // busy covers the start cycle and OUT, so those triggers are dropped
      if (trig && !busy) begin
        start  <= 1'b1;
        busy   <= 1'b1;
        rd_ptr <= wr_ptr;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            start <= 1'b0;
            k     <= '0;
            acc   <= '0;
            state <= ST_MAC;
          end
        end
        ST_MAC: begin
          acc <= acc + ACCW'(prod);
          if (k == TAPW'(TAPS - 1)) state <= ST_ROUND;
          else k <= k + TAPW'(1);
        end
        ST_ROUND: begin
          acc   <= (acc + RND_HALF) >>> SHIFT;
          state <= ST_OUT;
        end
        ST_OUT: begin
          if (acc > OUT_MAX) data_out <= OUT_MAX[WIDTHR-1:0];
          else if (acc < OUT_MIN) data_out <= OUT_MIN[WIDTHR-1:0];
          else data_out <= acc[WIDTHR-1:0];
          data_out_valid <= 1'b1;
          busy           <= 1'b0;
          state          <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/cic_comp_fir.md
CIC_COMP_FIR -- requirements
Module: cic_comp_fir

Interface
REQ-001 Parameter WIDTH, default 16, sets the input sample width (two's complement).
REQ-002 Parameter DECIM, default 2, sets the decimation factor; legal range 1..8.
REQ-003 Parameter WIDTHR, default 16, sets the result width.
REQ-004 Port clock, input, 1 bit: the single clock; all logic is rising-edge.
REQ-005 Port clock_areset_n, input, 1 bit: asynchronous active-low reset.
REQ-006 Port data_in_valid, input, 1 bit: qualifies data_in; single-cycle pulses from the upstream CIC decimator.
REQ-007 Port data_in, input, signed WIDTH bits: CIC output sample.
REQ-008 Port data_out_valid, output, 1 bit: one-cycle pulse qualifying data_out.
REQ-009 Port data_out, output, signed WIDTHR bits: droop-compensated, decimated sample.
REQ-010 Port busy, output, 1 bit: high while the MAC engine is not IDLE.
REQ-011 Port overrun, output, 1 bit: sticky; set when an output trigger arrives while busy.
REQ-012 Port overrun_clear, input, 1 bit: synchronous clear of overrun; set wins if both occur in the same cycle.

Function
REQ-013 The block SHALL implement a TAPS-tap FIR with COEFW-bit signed coefficients COEFS[0..TAPS-1] taken from the package, computing y = sum COEFS[k]*x[n-k].
REQ-014 Each data_in_valid SHALL write data_in into a circular sample buffer of depth DEPTH = 2^ceil(log2(TAPS+DECIM)) and advance the write pointer modulo DEPTH.
REQ-015 A phase counter SHALL count valid samples modulo DECIM; the valid sample taking it from DECIM-1 to 0 is the trigger sample.
REQ-016 On a trigger with the engine IDLE, the engine SHALL snapshot the trigger sample's address as base and leave IDLE on the next edge.
REQ-017 FSM states: IDLE -> MAC on trigger; MAC for exactly TAPS cycles, k = 0..TAPS-1, accumulating COEFS[k]*buf[base-k mod DEPTH]; MAC -> ROUND; ROUND -> OUT; OUT -> IDLE.
REQ-018 Accumulator width SHALL be WIDTH+COEFW+ceil(log2(TAPS)); the accumulator is cleared on entry to MAC.
REQ-019 ROUND SHALL add 2^(COEFW-2), arithmetically shift right by COEFW-1, and saturate to the signed WIDTHR range.
REQ-020 data_out_valid SHALL pulse in OUT, exactly TAPS+3 cycles after the edge that captured the trigger sample; data_out holds its value until the next OUT.
REQ-021 Samples arriving while busy SHALL still be written; the buffer sizing guarantees the snapshot window is not overwritten for up to DEPTH-TAPS such writes.
REQ-022 A trigger arriving while busy SHALL be dropped (no output) and SHALL set overrun; the phase counter continues normally.
REQ-023 A trigger arriving in the same cycle the engine returns to IDLE (OUT state) SHALL be treated as busy (dropped, overrun set).
REQ-024 With DECIM=1 every valid sample is a trigger.

Reset
REQ-025 Asserting clock_areset_n low SHALL immediately force: data_out_valid=0, data_out=0, busy=0, overrun=0, FSM=IDLE, write pointer=0, phase counter=0, accumulator=0.
REQ-026 Sample buffer contents SHALL be zeroed by reset, so that the first outputs after reset reflect zero history.
REQ-027 Reset asserted during MAC SHALL abort the computation with no data_out_valid pulse.

Structure
REQ-028 Package cic_comp_pkg SHALL hold TAPS (default 31), COEFW (default 18), COEFS (inverse-sinc compensator, symmetric), and the FSM state enum.
REQ-029 The sample buffer SHALL be a sub-module cic_comp_sample_ram (1 write port, 1 registered read port, DEPTH x WIDTH); its read latency is absorbed in the MAC pipeline without changing REQ-020.

Verification
REQ-030 Impulse: DECIM=2, one sample 1 followed by zeros scaled so x=2^(WIDTH-1)-1, samples 100 cycles apart -> outputs equal COEFS at even k (rounded per REQ-019), then 0.
REQ-031 DC: constant data_in=1000 -> steady-state data_out = round(1000*sum(COEFS)/2^(COEFW-1)), within +/-1 LSB.
REQ-032 Saturation: constant data_in=32767 with coefficient gain >1 -> data_out=32767; -32768 -> data_out=-32768.
REQ-033 Overrun: data_in_valid high every cycle -> overrun set at the second trigger and held until overrun_clear, and output count equals the number of accepted triggers.
REQ-034 Reset mid-MAC: assert clock_areset_n low at k=10 -> outputs zero immediately, no data_out_valid; first post-reset output is computed from post-reset samples only.
REQ-035 Latency: trigger captured at edge t -> data_out_valid high only at edge t+TAPS+3 (t+34 for defaults).
